// File: rtl/joy_md_pkg.sv
// Shared types and bit positions for the Mega Drive / DB9 pad scanner.
// Word layout matches the per-player joystick words used by the emu top.
package joy_md_pkg;

   typedef enum logic [3:0] {
      SETTLE,
      S1,
      S2,
      S3,
      S4,
      S5,
      S6,
      S7,
      S8,
      IDLE
   } state_t;

   localparam int BIT_R     = 0;
   localparam int BIT_L     = 1;
   localparam int BIT_D     = 2;
   localparam int BIT_U     = 3;
   localparam int BIT_A     = 4;
   localparam int BIT_B     = 5;
   localparam int BIT_C     = 6;
   localparam int BIT_X     = 7;
   localparam int BIT_Y     = 8;
   localparam int BIT_Z     = 9;
   localparam int BIT_START = 10;
   localparam int BIT_MODE  = 11;

   localparam int PIN_R  = 0;
   localparam int PIN_L  = 1;
   localparam int PIN_D  = 2;
   localparam int PIN_U  = 3;
   localparam int PIN_P6 = 4;
   localparam int PIN_P9 = 5;

endpackage

// File: rtl/joy_md_scan_if.sv
// Pad-side user port and the published per-player button words.
// The scanner is the master; the pads/consumer side is the slave.
interface joy_md_scan_if;

   logic [5:0]  joy_in;
   logic        joy_split;
   logic        joy_mdsel;
   logic [15:0] joystick1;
   logic [15:0] joystick2;
   logic [1:0]  six_btn;

   modport master (
      input  joy_in,
      output joy_split,
      output joy_mdsel,
      output joystick1,
      output joystick2,
      output six_btn
   );

   modport slave (
      output joy_in,
      input  joy_split,
      input  joy_mdsel,
      input  joystick1,
      input  joystick2,
      input  six_btn
   );

endinterface

// File: rtl/md_step_timer.sv
// Free-running protocol step timer; step_end marks the last cycle of a step.
module md_step_timer #(
   parameter int STEP_CYCLES = 512
) (
   input  logic clk,
   input  logic reset_n,
   input  logic restart,
   output logic step_end
);

   localparam int W = $clog2(STEP_CYCLES);

   logic [W-1:0] cnt;

   assign step_end = (cnt == W'(STEP_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (!reset_n || restart) begin
         cnt <= '0;
      end else if (step_end) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/joy_md_scan.sv
// Two-player Mega Drive 6-button pad scanner over a shared 6-line port.
// Words are assembled during the scan and committed in one cycle at S8.
module joy_md_scan
   import joy_md_pkg::*;
#(
   parameter int STEP_CYCLES = 512,
   parameter int IDLE_STEPS  = 160
) (
   input  logic          clk,
   input  logic          reset_n,
   joy_md_scan_if.master pad
);

   localparam int IW = $clog2(IDLE_STEPS + 1);

   state_t        st;
   state_t        nxt;
   logic          step_end;
   logic [5:0]    sync1;
   logic [5:0]    sync2;
   logic [5:0]    pin;
   logic [11:0]   acc;
   logic [11:0]   word;
   logic          md;
   logic          six;
   logic          split;
   logic          mdsel;
   logic [IW-1:0] idle_cnt;
   logic          idle_last;

   md_step_timer #(
      .STEP_CYCLES(STEP_CYCLES)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .restart  (1'b0),
      .step_end (step_end)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         sync1 <= '1;
         sync2 <= '1;
      end else begin
         sync1 <= pad.joy_in;
         sync2 <= sync1;
      end
   end

   assign pin       = ~sync2;
   assign idle_last = (idle_cnt == IW'(IDLE_STEPS - 1));

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         st <= SETTLE;
      end else begin
         st <= nxt;
      end
   end

   always_comb begin
      nxt = st;
      if (step_end) begin
         unique case (st)
            SETTLE:  nxt = S1;
            S1:      nxt = S2;
            S2:      nxt = S3;
            S3:      nxt = S4;
            S4:      nxt = S5;
            S5:      nxt = S6;
            S6:      nxt = S7;
            S7:      nxt = S8;
            S8:      nxt = split ? IDLE : SETTLE;
            IDLE:    nxt = idle_last ? SETTLE : IDLE;
            default: nxt = SETTLE;
         endcase
      end
   end

   always_comb begin
      mdsel = 1'b1;
      unique case (st)
         S2, S4, S6, S8: mdsel = 1'b0;
         default:        mdsel = 1'b1;
      endcase
   end

   assign pad.joy_mdsel = mdsel;
   assign pad.joy_split = split;

   // Stale A/Start/XYZ/Mode from an earlier scan are masked by class.
   always_comb begin
      word = acc;
      if (!md) begin
         word[BIT_A]     = 1'b0;
         word[BIT_START] = 1'b0;
      end
      if (!six) begin
         word[BIT_X]    = 1'b0;
         word[BIT_Y]    = 1'b0;
         word[BIT_Z]    = 1'b0;
         word[BIT_MODE] = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         split         <= 1'b0;
         idle_cnt      <= '0;
         acc           <= '0;
         md            <= 1'b0;
         six           <= 1'b0;
         pad.joystick1 <= '0;
         pad.joystick2 <= '0;
         pad.six_btn   <= '0;
      end else if (step_end) begin
         unique case (st)
            S1: begin
               acc[BIT_R] <= pin[PIN_R];
               acc[BIT_L] <= pin[PIN_L];
               acc[BIT_D] <= pin[PIN_D];
               acc[BIT_U] <= pin[PIN_U];
               acc[BIT_B] <= pin[PIN_P6];
               acc[BIT_C] <= pin[PIN_P9];
            end
            S2: begin
               acc[BIT_A]     <= pin[PIN_P6];
               acc[BIT_START] <= pin[PIN_P9];
               md             <= pin[PIN_L] & pin[PIN_R];
            end
            S6: six <= md & (&pin[PIN_U:PIN_R]);
            S7: begin
               if (six) begin
                  acc[BIT_Z]    <= pin[PIN_U];
                  acc[BIT_Y]    <= pin[PIN_D];
                  acc[BIT_X]    <= pin[PIN_L];
                  acc[BIT_MODE] <= pin[PIN_R];
               end
            end
            S8: begin
               if (split) begin
                  pad.joystick2  <= {4'h0, word};
                  pad.six_btn[1] <= six;
               end else begin
                  pad.joystick1  <= {4'h0, word};
                  pad.six_btn[0] <= six;
               end
               split <= ~split;
            end
            IDLE: idle_cnt <= idle_last ? '0 : idle_cnt + 1'b1;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_joy_md_scan.sv
// Directed bench for joy_md_scan with behavioural none/Atari/3/6-button pads.
// Expected commits are queued as pads are configured and checked as they land.
module tb_joy_md_scan;

   localparam int STEP = 4;
   localparam int IDLE = 3;

   typedef struct {
      int          p;
      logic [15:0] w;
      logic        six;
   } exp_t;

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   joy_md_scan_if bus ();

   joy_md_scan #(
      .STEP_CYCLES(STEP),
      .IDLE_STEPS (IDLE)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .pad     (bus)
   );

   always #5 clk = ~clk;

   // pad types: 0 none, 1 Atari, 2 3-button, 3 6-button
   logic [1:0]  ptyp[2];
   logic [11:0] held[2];
   logic [2:0]  lows[2] = '{3'd0, 3'd0};
   int          hi[2]   = '{0, 0};
   logic        prev_sel[2] = '{1'b1, 1'b1};
   logic        sel[2];

   exp_t        sb[$];
   logic [15:0] last_word[2];
   int          n_assert = 0;
   int          n_fail = 0;

   function automatic logic [5:0] pad_pins(input logic [1:0] typ,
                                           input logic [11:0] h,
                                           input logic s,
                                           input logic [2:0] lc);
      logic [5:0] a;
      a = '0;
      case (typ)
         2'd0: a = '0;
         2'd1: a = {h[6], h[5], h[3], h[2], h[1], h[0]};
         default: begin
            if (typ == 2'd3 && lc == 3'd3)
               a = s ? {h[6], h[5], h[9], h[8], h[7], h[11]}
                     : {h[10], h[4], 4'hF};
            else
               a = s ? {h[6], h[5], h[3], h[2], h[1], h[0]}
                     : {h[10], h[4], h[3], h[2], 2'b11};
         end
      endcase
      return ~a;
   endfunction

   always_comb begin
      sel[0] = bus.joy_split ? 1'b1 : bus.joy_mdsel;
      sel[1] = bus.joy_split ? bus.joy_mdsel : 1'b1;
      bus.joy_in = bus.joy_split ? pad_pins(ptyp[1], held[1], sel[1], lows[1])
                                 : pad_pins(ptyp[0], held[0], sel[0], lows[0]);
   end

   // 6-button counter: counts select falls, clears after a long high
   always @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         prev_sel[p] <= sel[p];
         if (sel[p]) begin
            hi[p] <= hi[p] + 1;
            if (hi[p] >= 6) lows[p] <= 3'd0;
         end else begin
            hi[p] <= 0;
            if (prev_sel[p] && lows[p] != 3'd7) lows[p] <= lows[p] + 3'd1;
         end
      end
   end

   function automatic logic [15:0] word_of(input int p);
      return (p == 1) ? bus.joystick2 : bus.joystick1;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic push(input int p, input logic [15:0] w, input logic six);
      exp_t e;
      e.p = p;
      e.w = w;
      e.six = six;
      sb.push_back(e);
   endtask

   task automatic wait_commit(output int waited);
      logic        prev;
      logic        seen;
      logic [15:0] before_p;
      logic [15:0] before_o;
      int          p;
      exp_t        e;
      prev = bus.joy_split;
      p = int'(prev);
      seen = 1'b0;
      waited = 0;
      before_p = '0;
      before_o = '0;
      while (!seen && waited < 400) begin
         before_p = word_of(p);
         before_o = word_of(1 - p);
         @(negedge clk);
         waited++;
         if (bus.joy_split !== prev) seen = 1'b1;
      end
      check("commit_seen", 32'(seen), 32'd1);
      if (seen && sb.size() > 0) begin
         e = sb.pop_front();
         check("commit_player", p, e.p);
         check("pre_commit_hold", before_p, last_word[p]);
         check("other_pre_hold", before_o, last_word[1 - p]);
         check("commit_word", word_of(p), e.w);
         check("commit_six", bus.six_btn[p], e.six);
         check("other_hold", word_of(1 - p), last_word[1 - p]);
         last_word[p] = e.w;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int w;
      int idx;
      logic exp_sel;
      ptyp[0] = 2'd0;
      ptyp[1] = 2'd0;
      held[0] = '0;
      held[1] = '0;
      last_word[0] = '0;
      last_word[1] = '0;

      // reset values
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_joystick1", bus.joystick1, 16'h0000);
      check("rst_joystick2", bus.joystick2, 16'h0000);
      check("rst_six_btn", bus.six_btn, 2'b00);
      check("rst_split", bus.joy_split, 1'b0);
      check("rst_mdsel", bus.joy_mdsel, 1'b1);
      reset_n = 1'b1;

      // no pads: select pattern for both players
      repeat (2) @(negedge clk);
      for (int k = 0; k < 18; k++) begin
         idx = k % 9;
         exp_sel = (idx < 2) ? 1'b1 : ((idx % 2) == 1);
         check("mdsel_step", bus.joy_mdsel, exp_sel);
         check("split_step", bus.joy_split, (k >= 9) ? 1'b1 : 1'b0);
         repeat (STEP) @(negedge clk);
      end
      push(0, 16'h0000, 1'b0);
      push(1, 16'h0000, 1'b0);
      wait_commit(w);
      wait_commit(w);

      // 3-button on player 1: Up + A + Start
      ptyp[0] = 2'd2;
      held[0] = 12'h418;
      push(0, 16'h0418, 1'b0);
      push(1, 16'h0000, 1'b0);
      wait_commit(w);
      wait_commit(w);

      // 6-button on player 2: Right + X + Mode
      ptyp[1] = 2'd3;
      held[1] = 12'h881;
      push(0, 16'h0418, 1'b0);
      push(1, 16'h0881, 1'b1);
      wait_commit(w);
      wait_commit(w);
      check("six_btn_p2", bus.six_btn, 2'b10);

      // Atari on player 1: Left + pin6
      ptyp[0] = 2'd1;
      held[0] = 12'h022;
      push(0, 16'h0022, 1'b0);
      push(1, 16'h0881, 1'b1);
      wait_commit(w);
      wait_commit(w);

      // reset pulse during S5 of player 2
      push(0, 16'h0022, 1'b0);
      wait_commit(w);
      repeat (5 * STEP + 1) @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      check("mid_rst_joystick1", bus.joystick1, 16'h0000);
      check("mid_rst_joystick2", bus.joystick2, 16'h0000);
      check("mid_rst_six_btn", bus.six_btn, 2'b00);
      check("mid_rst_split", bus.joy_split, 1'b0);
      check("mid_rst_mdsel", bus.joy_mdsel, 1'b1);
      reset_n = 1'b1;
      last_word[0] = '0;
      last_word[1] = '0;
      push(0, 16'h0022, 1'b0);
      wait_commit(w);
      check("rst_to_commit_cycles", w, 9 * STEP);

      // Down pressed during S4 of player 1: lands one scan later
      push(1, 16'h0881, 1'b1);
      wait_commit(w);
      repeat ((IDLE + 4) * STEP + 1) @(negedge clk);
      check("pin_change_state", {bus.joy_split, bus.joy_mdsel}, 2'b00);
      held[0] = 12'h026;
      push(0, 16'h0022, 1'b0);
      push(1, 16'h0881, 1'b1);
      push(0, 16'h0026, 1'b0);
      wait_commit(w);
      wait_commit(w);
      wait_commit(w);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
